// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: two-master round-robin arbiter and access sequencer owning data_memory's single port.
// Define DMEM_ARB_FIXED_PRIORITY_EN to make m0 win every tie (no round-robin history kept).
module data_memory_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_control_signal,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_output_data
);

  // state  | meaning
  // IDLE   | nothing in flight, arbitrates on every edge
  // ACCESS | memory port driven from latched operands, gnt pulse to owner
  // RESP   | done pulse to owner, read data passed through, re-arbitrates
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              owner;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              any_req;
  logic              winner;

  assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
  assign winner = ~m0_req;
`else
  logic last;
  // On a tie the master that did not win last time goes next.
  assign winner = (m0_req && m1_req) ? ~last : m1_req;
`endif

  // Operand registers double as the memory port so it holds its last value outside ACCESS.
  assign mem_address        = op_addr;
  assign mem_write_data     = op_wdata;
  assign mem_control_signal = op_we && (state == ACCESS);

  assign m0_rdata = m0_done ? mem_output_data : '0;
  assign m1_rdata = m1_done ? mem_output_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
`else
      last     <= 1'b1;
`endif
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        ACCESS: begin
          state   <= RESP;
          m0_done <= ~owner;
          m1_done <= owner;
        end
        default: begin
          if (any_req) begin
            state    <= ACCESS;
            owner    <= winner;
            op_we    <= winner ? m1_we    : m0_we;
            op_addr  <= winner ? m1_addr  : m0_addr;
            op_wdata <= winner ? m1_wdata : m0_wdata;
            m0_gnt   <= ~winner;
            m1_gnt   <= winner;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
`else
            last     <= winner;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model. Honors DMEM_ARB_FIXED_PRIORITY_EN for tie expectations.
module tb_data_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [63:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [63:0] m0_rdata, m1_rdata;
  logic        mem_control_signal;
  logic [63:0] mem_address, mem_write_data, mem_output_data;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] emu    [logic [63:0]];
  logic [63:0] refmem [logic [63:0]];

  data_memory_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_control_signal(mem_control_signal), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_output_data(mem_output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: write on falling edge, registered read on rising edge.
  always @(negedge clk) if (mem_control_signal) emu[mem_address] = mem_write_data;
  always @(posedge clk) mem_output_data <= emu.exists(mem_address) ? emu[mem_address] : 64'd0;

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return refmem.exists(a) ? refmem[a] : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    vectors++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_control_signal} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected 00000", {m0_gnt, m1_gnt, m0_done, m1_done, mem_control_signal});
    end
    vectors++;
    if ({m0_rdata, m1_rdata, mem_address, mem_write_data} !== 256'd0) begin
      miscompares++;
      $display("FAIL reset_data: got r0=%0h r1=%0h a=%0h wd=%0h expected all 0", m0_rdata, m1_rdata, mem_address, mem_write_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 64'd5; m0_wdata = 64'hDEAD;
    tick();
    vectors++;
    if ({m0_gnt, m1_gnt, m0_done, mem_control_signal} !== 4'b1001 || mem_address !== 64'd5 || mem_write_data !== 64'hDEAD) begin
      miscompares++;
      $display("FAIL wr_access: got gnt0=%b gnt1=%b done0=%b we=%b a=%0h wd=%0h expected 1 0 0 1 5 dead",
               m0_gnt, m1_gnt, m0_done, mem_control_signal, mem_address, mem_write_data);
    end
    m0_req = 1'b0;
    tick();
    vectors++;
    if ({m0_gnt, m0_done, mem_control_signal} !== 3'b010 || mem_address !== 64'd5) begin
      miscompares++;
      $display("FAIL wr_resp: got gnt0=%b done0=%b we=%b a=%0h expected 0 1 0 5", m0_gnt, m0_done, mem_control_signal, mem_address);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd5;
    tick();
    vectors++;
    if ({m0_gnt, mem_control_signal} !== 2'b10 || mem_address !== 64'd5) begin
      miscompares++;
      $display("FAIL rd_access: got gnt0=%b we=%b a=%0h expected 1 0 5", m0_gnt, mem_control_signal, mem_address);
    end
    m0_req = 1'b0;
    tick();
    vectors++;
    if (m0_done !== 1'b1 || m0_rdata !== 64'hDEAD || m1_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL rd_resp: got done0=%b r0=%0h r1=%0h expected 1 dead 0", m0_done, m0_rdata, m1_rdata);
    end
    tick();
    vectors++;
    if (m0_done !== 1'b0 || m0_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL rd_idle: got done0=%b r0=%0h expected 0 0", m0_done, m0_rdata);
    end
  endtask

  task automatic test_m1_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 64'd1024; m0_wdata = 64'h1234;
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'd1024;
    tick();
    vectors++;
    if ({m1_gnt, m0_gnt, mem_control_signal} !== 3'b100 || mem_address !== 64'd1024) begin
      miscompares++;
      $display("FAIL m1_access: got gnt1=%b gnt0=%b we=%b a=%0h expected 1 0 0 400", m1_gnt, m0_gnt, mem_control_signal, mem_address);
    end
    m1_req = 1'b0;
    tick();
    vectors++;
    if (m1_done !== 1'b1 || m1_rdata !== 64'h1234 || m0_done !== 1'b0 || m0_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL m1_resp: got done1=%b r1=%0h done0=%b r0=%0h expected 1 1234 0 0", m1_done, m1_rdata, m0_done, m0_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic eg0, eg1, ed0, ed1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'd2;
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      eg0 = (k % 2 == 0); ed0 = (k % 2 == 1); eg1 = 1'b0; ed1 = 1'b0;
`else
      eg0 = (k % 4 == 0); ed0 = (k % 4 == 1); eg1 = (k % 4 == 2); ed1 = (k % 4 == 3);
`endif
      vectors++;
      if ({m0_gnt, m1_gnt, m0_done, m1_done} !== {eg0, eg1, ed0, ed1}) begin
        miscompares++;
        $display("FAIL contend[%0d]: got g0g1d0d1=%b expected %b", k, {m0_gnt, m1_gnt, m0_done, m1_done}, {eg0, eg1, ed0, ed1});
      end
      if (m0_gnt || m1_gnt) begin
        vectors++;
        if (mem_address !== (m1_gnt ? 64'd2 : 64'd1)) begin
          miscompares++;
          $display("FAIL contend_addr[%0d]: got %0h expected %0h", k, mem_address, m1_gnt ? 64'd2 : 64'd1);
        end
      end
    end
    m0_req = 1'b0;
    tick();
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL m0_drop: got g0g1=%b expected 01", {m0_gnt, m1_gnt});
    end
    m1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 64'd7; m0_wdata = 64'hBEEF;
    tick();
    vectors++;
    if ({m0_gnt, mem_control_signal} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_pre: got gnt0=%b we=%b expected 1 1", m0_gnt, mem_control_signal);
    end
    m0_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_control_signal} !== 5'b0 || {mem_address, mem_write_data, m0_rdata, m1_rdata} !== 256'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got ctl=%b a=%0h wd=%0h expected 0 0 0",
               {m0_gnt, m1_gnt, m0_done, m1_done, mem_control_signal}, mem_address, mem_write_data);
    end
    tick();
    vectors++;
    if ({m0_done, m0_gnt, mem_control_signal} !== 3'b0) begin
      miscompares++;
      $display("FAIL mid_nodone: got done0=%b gnt0=%b we=%b expected 0 0 0", m0_done, m0_gnt, mem_control_signal);
    end
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 64'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 64'd2;
    tick();
    vectors++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset_tie: got g0g1=%b expected 10", {m0_gnt, m1_gnt});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
  endtask

  // Transaction model: one access at a time, next arbitration two edges after a grant.
  task automatic test_random(input int n);
    logic        r [2];
    logic        w [2];
    logic [63:0] a [2];
    logic [63:0] d [2];
    int          g_cur, d_cur, free_edge, last_m;
    logic        g_we, d_we;
    logic [63:0] g_addr, g_wd, g_rd, d_rd;
    logic        gr0, gr1, dn0, dn1;
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin r[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; end
    g_cur = -1; d_cur = -1; free_edge = 0; last_m = 1;
    g_we = 1'b0; d_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0; d_rd = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      d_cur = g_cur; d_we = g_we; d_rd = g_rd;
      g_cur = -1;
      if (c >= free_edge && (r[0] || r[1])) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
        g_cur = r[0] ? 0 : 1;
`else
        g_cur = (r[0] && r[1]) ? 1 - last_m : (r[0] ? 0 : 1);
`endif
        last_m = g_cur; free_edge = c + 2;
        g_we = w[g_cur]; g_addr = a[g_cur]; g_wd = d[g_cur];
        if (g_we) refmem[g_addr] = g_wd;
        else g_rd = ref_rd(g_addr);
      end
      #1;
      gr0 = (g_cur == 0); gr1 = (g_cur == 1); dn0 = (d_cur == 0); dn1 = (d_cur == 1);
      vectors++;
      if ({m0_gnt, m1_gnt, m0_done, m1_done} !== {gr0, gr1, dn0, dn1}) begin
        miscompares++;
        $display("FAIL rnd_hs[%0d]: got g0g1d0d1=%b expected %b", c, {m0_gnt, m1_gnt, m0_done, m1_done}, {gr0, gr1, dn0, dn1});
      end
      vectors++;
      if (mem_control_signal !== (g_cur >= 0 && g_we)) begin
        miscompares++;
        $display("FAIL rnd_we[%0d]: got %b expected %b", c, mem_control_signal, (g_cur >= 0 && g_we));
      end
      if (g_cur >= 0) begin
        vectors++;
        if (mem_address !== g_addr || (g_we && mem_write_data !== g_wd)) begin
          miscompares++;
          $display("FAIL rnd_port[%0d]: got a=%0h wd=%0h expected a=%0h wd=%0h", c, mem_address, mem_write_data, g_addr, g_wd);
        end
      end
      if (d_cur >= 0 && !d_we) begin
        vectors++;
        if ((d_cur == 0 ? m0_rdata : m1_rdata) !== d_rd) begin
          miscompares++;
          $display("FAIL rnd_rdata[%0d]: got %0h expected %0h", c, (d_cur == 0 ? m0_rdata : m1_rdata), d_rd);
        end
      end
      vectors++;
      if ((d_cur != 0 && m0_rdata !== 64'd0) || (d_cur != 1 && m1_rdata !== 64'd0)) begin
        miscompares++;
        $display("FAIL rnd_rzero[%0d]: got r0=%0h r1=%0h expected 0 on idle master", c, m0_rdata, m1_rdata);
      end
      for (int i = 0; i < 2; i++) begin
        if (g_cur == i) r[i] = ($urandom_range(0, 1) == 1);
        else if (!r[i]) r[i] = ($urandom_range(0, 2) == 0);
        if (r[i] && (g_cur == i || !((i == 0) ? m0_req : m1_req))) begin
          w[i] = $urandom_range(0, 1);
          a[i] = 64'h100 + 64'($urandom_range(0, 15));
          d[i] = {$urandom, $urandom};
        end
      end
      m0_req = r[0]; m0_we = w[0]; m0_addr = a[0]; m0_wdata = d[0];
      m1_req = r[1]; m1_we = w[1]; m1_addr = a[1]; m1_wdata = d[1];
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_write_read();
    test_m1_read();
    test_contention();
    test_reset_mid_access();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer for the shared `data_memory` block. It accepts load/store requests from two masters, such as the load/store unit and a debug/DMA port. It grants one request at a time using round-robin priority and drives the memory's single port. It returns read data, or write completion, to the winning master. It sits between the masters and `data_memory`, and owns all of that memory's inputs.

## Interface
- `ADDR_W`, 64, address width; forwarded unchanged to memory, which is word-indexed.
- `DATA_W`, 64, data width.

- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request; held high until grant is seen
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; valid with req
- `m0_addr`, `m1_addr`  in  ADDR_W  word address; valid with req
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; valid with req
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: request accepted and operands latched
- `m0_done`, `m1_done`  out  1  one-cycle pulse: access complete
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data; meaningful only while the matching done is high after a read
- `mem_control_signal`  out  1  memory write enable
- `mem_address`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_output_data`  in  DATA_W  registered memory read data, one cycle latency

## Operation
- FSM states and transitions:
  - IDLE: no request pending. Any req -> ACCESS. No req -> stay in IDLE.
  - ACCESS: memory is being driven. Always -> RESP.
  - RESP: completion is signalled. Arbitration runs again here: any req -> ACCESS, otherwise -> IDLE.
- Arbitration happens on the rising edge while in IDLE or RESP:
  - Only one req high: that master wins.
  - Both reqs high: the master not in `last` wins.
  - On a win, the winner's `we`/`addr`/`wdata` are latched into `owner`/`op_we`/`op_addr`/`op_wdata`, and `last` <= winner.
- ACCESS state:
  - `mem_address` = `op_addr`.
  - `mem_write_data` = `op_wdata`.
  - `mem_control_signal` = `op_we`.
  - `m<owner>_gnt` = 1.
- Memory-port outputs are stable across the whole ACCESS cycle. This holds the memory's falling-edge write and rising-edge read valid.
- Outside ACCESS, `mem_control_signal` = 0. `mem_address` and `mem_write_data` hold their last values.
- RESP state:
  - `m<owner>_done` = 1.
  - `m<owner>_rdata` = `mem_output_data` (combinational passthrough).
  - The non-owner's rdata is 0.
- Write responses also pulse done; rdata content is then don't-care.
- A master must keep req high until it sees gnt, then drop req in the same cycle or reissue a new request. A req still high in RESP is treated as a new request.
- Reset values:
  - State IDLE; `last` = 1, so m0 wins the first tie.
  - All gnt, done and rdata outputs = 0.
  - `mem_control_signal` = 0, `mem_address` = 0, `mem_write_data` = 0.
- Reset asserted mid-ACCESS drops `mem_control_signal` immediately. An in-flight write may not commit and an in-flight read is abandoned; no done is issued.

## Timing
- req is sampled at edge T:
  - ACCESS runs T..T+1, with gnt high.
  - A write commits at the falling edge inside that cycle.
  - Memory captures the read at T+1.
  - RESP runs T+1..T+2, with done high and rdata valid.
- Request-to-done latency: 2 cycles.
- Back-to-back throughput: one access per 2 cycles, since RESP re-arbitrates.
- A master never receives two grants without an intervening done.
- Under continuous contention, grants strictly alternate m0, m1, m0, …

## Configuration
- `DMEM_ARB_FIXED_PRIORITY_EN` defined:
  - m0 always wins a tie.
  - `last` is not implemented.
  - m1 is served only when m0_req is low at the arbitration edge.
- Undefined: round-robin as described in Operation.

## Test plan
- Reset, then m0 write (addr 5, data 0xDEAD) -> gnt0 1 cycle after sample; mem_control_signal high exactly one cycle; done0 next cycle; then m0 read addr 5 -> done0 with rdata0 = 0xDEAD.
- Both masters request every cycle from reset (m0 addr 1, m1 addr 2) -> grant order m0, m1, m0, m1; gnt spacing 2 cycles; no overlap.
- m1 read alone at addr 1024 after m0 wrote 0x1234 there -> done1 two cycles after req; rdata1 = 0x1234; done0 stays 0 and rdata0 stays 0.
- Reset asserted during ACCESS of an m0 write -> mem_control_signal = 0 combinationally; no done0; all outputs at reset values; first post-reset tie granted to m0.
- With `DMEM_ARB_FIXED_PRIORITY_EN`, both reqs held for 4 accesses -> all 4 granted to m0; m1 granted on the first arbitration edge after m0_req drops.
